// File: rtl/compare_swap_sorter.sv
// Sequential ascending sorter: loads DEPTH words, bubble-sorts them in place with
// one shared comparator (early exit on a clean pass), then streams them out.
module compare_swap_sorter #(
  parameter int unsigned N     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic [7:0]   swap_count
);

  localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  state_t           state, state_next;
  logic [N-1:0]     mem [DEPTH];
  logic [N-1:0]     mem_next [DEPTH];
  logic [IDX_W-1:0] load_idx, load_idx_next;
  logic [IDX_W-1:0] cmp_idx, cmp_idx_next, cmp_idx_p1;
  logic [IDX_W-1:0] pass_idx, pass_idx_next;
  logic [IDX_W-1:0] out_idx, out_idx_next;
  logic             pass_swapped, pass_swapped_next;
  logic [7:0]       swap_count_next;
  logic [N-1:0]     out_data_next;
  logic [N-1:0]     lhs, rhs;
  logic             gt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_next        = state;
    mem_next          = mem;
    load_idx_next     = load_idx;
    cmp_idx_next      = cmp_idx;
    pass_idx_next     = pass_idx;
    out_idx_next      = out_idx;
    pass_swapped_next = pass_swapped;
    swap_count_next   = swap_count;
    out_data_next     = out_data;
    cmp_idx_p1        = cmp_idx + IDX_W'(1);
    lhs               = mem[cmp_idx];
    rhs               = mem[cmp_idx_p1];
    gt                = lhs > rhs;

    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          mem_next[load_idx] = in_data;
          if (load_idx == LAST_IDX) begin
            state_next        = SORT;
            load_idx_next     = '0;
            cmp_idx_next      = '0;
            pass_idx_next     = '0;
            pass_swapped_next = 1'b0;
            swap_count_next   = 8'd0;
          end else begin
            load_idx_next = load_idx + IDX_W'(1);
          end
        end
      end
      SORT: begin
        if (gt) begin
          mem_next[cmp_idx]    = rhs;
          mem_next[cmp_idx_p1] = lhs;
          if (swap_count != 8'hFF) swap_count_next = swap_count + 8'd1;
        end
        // Pass p covers positions 0..DEPTH-2-p; a clean pass ends the sort early
        if (cmp_idx < (LAST_PASS - pass_idx)) begin
          cmp_idx_next      = cmp_idx_p1;
          pass_swapped_next = pass_swapped | gt;
        end else if (!(pass_swapped || gt) || (pass_idx == LAST_PASS)) begin
          state_next   = OUT;
          out_idx_next = '0;
        end else begin
          pass_idx_next     = pass_idx + IDX_W'(1);
          cmp_idx_next      = '0;
          pass_swapped_next = 1'b0;
        end
      end
      OUT: begin
        if (out_valid && out_ready) begin
          if (out_idx == LAST_IDX) begin
            state_next   = LOAD;
            out_idx_next = '0;
          end else begin
            out_idx_next = out_idx + IDX_W'(1);
          end
        end
      end
      default: state_next = LOAD;
    endcase

    // Look ahead through this cycle's swap so the first word is correct on OUT entry
    if (state_next == OUT) out_data_next = mem_next[out_idx_next];
  end

  // Storage, indices and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(DEPTH); k++) mem[k] <= '0;
      load_idx     <= '0;
      cmp_idx      <= '0;
      pass_idx     <= '0;
      out_idx      <= '0;
      pass_swapped <= 1'b0;
      swap_count   <= 8'd0;
      out_data     <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      mem          <= mem_next;
      load_idx     <= load_idx_next;
      cmp_idx      <= cmp_idx_next;
      pass_idx     <= pass_idx_next;
      out_idx      <= out_idx_next;
      pass_swapped <= pass_swapped_next;
      swap_count   <= swap_count_next;
      out_data     <= out_data_next;
      in_ready     <= (state_next == LOAD);
      out_valid    <= (state_next == OUT);
      busy         <= (state_next == SORT);
    end
  end

endmodule
